// File: rtl/mmio_arbiter.sv
// Two-master MMIO arbiter: IDLE/ACCESS/DONE sequencer in front of the DM/timer bridge.
// Optional MMIO_ARB_ROUND_ROBIN_EN selects alternating tie-break instead of fixed m0 priority.
module mmio_arbiter #(
    localparam int unsigned AW = 32,
    localparam int unsigned DW = 32,
    localparam int unsigned BW = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          m0_req,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_wdata,
    input  logic [BW-1:0] m0_byteen,
    output logic          m0_ack,
    output logic [DW-1:0] m0_rdata,
    output logic          m0_err,
    input  logic          m1_req,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wdata,
    input  logic [BW-1:0] m1_byteen,
    output logic          m1_ack,
    output logic [DW-1:0] m1_rdata,
    output logic          m1_err,
    output logic [AW-1:0] bus_addr,
    output logic [DW-1:0] bus_wdata,
    output logic [BW-1:0] bus_byteen,
    input  logic [DW-1:0] bus_rdata,
    output logic          busy
);

    localparam logic [AW-1:0] DM_LO  = AW'(32'h0000_0000);
    localparam logic [AW-1:0] DM_HI  = AW'(32'h0000_2FFF);
    localparam logic [AW-1:0] TC0_LO = AW'(32'h0000_7F00);
    localparam logic [AW-1:0] TC0_HI = AW'(32'h0000_7F0B);
    localparam logic [AW-1:0] TC1_LO = AW'(32'h0000_7F10);
    localparam logic [AW-1:0] TC1_HI = AW'(32'h0000_7F1B);
    localparam logic [AW-1:0] INT_A  = AW'(32'h0000_7F20);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [BW-1:0] byteen;
    } xact_t;

    state_t state;
    state_t state_nxt;
    logic   capture;
    logic   pick_m1;
    xact_t  winner;
    logic   winner_mapped;
    logic   hold_mapped;
    logic   last_grant;

    function automatic logic addr_mapped(input logic [AW-1:0] a);
        return ((a >= DM_LO)  && (a <= DM_HI))  ||
               ((a >= TC0_LO) && (a <= TC0_HI)) ||
               ((a >= TC1_LO) && (a <= TC1_HI)) ||
               (a == INT_A);
    endfunction

    // Arbitration: last_grant = 1 means m1 was served most recently.
    always_comb begin
        pick_m1 = 1'b0;
`ifdef MMIO_ARB_ROUND_ROBIN_EN
        pick_m1 = m1_req & (~m0_req | ~last_grant);
`else
        pick_m1 = m1_req & ~m0_req;
`endif
        winner = pick_m1 ? {m1_addr, m1_wdata, m1_byteen}
                         : {m0_addr, m0_wdata, m0_byteen};
        winner_mapped = addr_mapped(winner.addr);
    end

    // Next-state logic; requests are only looked at in IDLE.
    always_comb begin
        state_nxt = state;
        capture   = 1'b0;
        unique case (state)
            IDLE: begin
                if (m0_req || m1_req) begin
                    state_nxt = ACCESS;
                    capture   = 1'b1;
                end
            end
            ACCESS:  state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // bus_addr/bus_wdata double as the holding registers; bus_byteen is live only in ACCESS.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            busy        <= 1'b0;
            bus_addr    <= '0;
            bus_wdata   <= '0;
            bus_byteen  <= '0;
            hold_mapped <= 1'b0;
            last_grant  <= 1'b1;
            m0_ack      <= 1'b0;
            m1_ack      <= 1'b0;
            m0_err      <= 1'b0;
            m1_err      <= 1'b0;
            m0_rdata    <= '0;
            m1_rdata    <= '0;
        end else begin
            state      <= state_nxt;
            busy       <= (state_nxt != IDLE);
            bus_byteen <= '0;
            m0_ack     <= 1'b0;
            m1_ack     <= 1'b0;
            m0_err     <= 1'b0;
            m1_err     <= 1'b0;
            if (capture) begin
                bus_addr    <= winner.addr;
                bus_wdata   <= winner.wdata;
                bus_byteen  <= winner_mapped ? winner.byteen : '0;
                hold_mapped <= winner_mapped;
                last_grant  <= pick_m1;
            end
            if (state == ACCESS) begin
                if (last_grant) begin
                    m1_ack   <= 1'b1;
                    m1_err   <= ~hold_mapped;
                    m1_rdata <= hold_mapped ? bus_rdata : '0;
                end else begin
                    m0_ack   <= 1'b1;
                    m0_err   <= ~hold_mapped;
                    m0_rdata <= hold_mapped ? bus_rdata : '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_mmio_arbiter.sv
// Randomized scoreboard bench for mmio_arbiter: a transaction-level timing/arbitration model
// predicts each ack, its cycle and payload; a negedge monitor compares everything the DUT shows.
module tb_mmio_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        m0_req, m1_req;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic [3:0]  m0_byteen, m1_byteen;
    logic        m0_ack, m1_ack, m0_err, m1_err;
    logic [31:0] m0_rdata, m1_rdata;
    logic [31:0] bus_addr, bus_wdata, bus_rdata;
    logic [3:0]  bus_byteen;
    logic        busy;

    mmio_arbiter dut (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_byteen(m0_byteen),
        .m0_ack(m0_ack), .m0_rdata(m0_rdata), .m0_err(m0_err),
        .m1_req(m1_req), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_byteen(m1_byteen),
        .m1_ack(m1_ack), .m1_rdata(m1_rdata), .m1_err(m1_err),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_byteen(bus_byteen),
        .bus_rdata(bus_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          m;
        int          ack_cyc;
        bit          rd;
        logic [31:0] rdata;
        bit          err;
    } exp_t;

    exp_t        exp_q[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc = 0;
    int          cap = -100;
    int          last = 1;
    logic [3:0]  be_val;
    logic [31:0] be_addr, be_wdata;
    logic [31:0] salt;
    bit          mon_en = 1'b0;
    int          raise_pct = 0;
    logic [31:0] addr_tab [16];

    // Bridge model: read data is a fixed scramble of the address.
    always_comb bus_rdata = (bus_addr * 32'h9E37_79B1) ^ salt;

    function automatic bit is_mapped(input logic [31:0] a);
        return a inside {[32'h0000_0000:32'h0000_2FFF], [32'h0000_7F00:32'h0000_7F0B],
                         [32'h0000_7F10:32'h0000_7F1B], 32'h0000_7F20};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        n_cmp++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s @cyc %0d: got %h want %h", name, cyc, act, want);
        end
    endtask

    // Reference model: one transaction per 3 cycles, requests looked at only when free.
    always @(posedge clk) begin
        cyc++;
        if (reset) begin
            exp_q.delete();
            last = 1;
            cap  = -100;
        end else if (cyc >= cap + 3 && (m0_req || m1_req)) begin
            exp_t        e;
            int          w;
            logic [31:0] a;
            logic [3:0]  be;
            if (m0_req && m1_req) begin
`ifdef MMIO_ARB_ROUND_ROBIN_EN
                w = (last == 0) ? 1 : 0;
`else
                w = 0;
`endif
            end else begin
                w = m1_req ? 1 : 0;
            end
            a        = w ? m1_addr : m0_addr;
            be       = w ? m1_byteen : m0_byteen;
            be_addr  = a;
            be_wdata = w ? m1_wdata : m0_wdata;
            be_val   = is_mapped(a) ? be : 4'h0;
            e.m       = w;
            e.ack_cyc = cyc + 1;
            e.rd      = (be == 4'h0);
            e.err     = !is_mapped(a);
            e.rdata   = is_mapped(a) ? ((a * 32'h9E37_79B1) ^ salt) : 32'h0;
            exp_q.push_back(e);
            last = w;
            cap  = cyc;
        end
    end

    // Monitor: bus strobe window, busy, and ack scoreboard.
    always @(negedge clk) begin
        if (mon_en) begin
            chk("bus_byteen", 32'(bus_byteen), (cyc == cap) ? 32'(be_val) : 32'h0);
            if (cyc == cap) begin
                chk("bus_addr", bus_addr, be_addr);
                chk("bus_wdata", bus_wdata, be_wdata);
            end
            chk("busy", 32'(busy), 32'((cyc == cap) || (cyc == cap + 1)));
            chk("dual_ack", 32'(m0_ack & m1_ack), 32'h0);
            for (int m = 0; m < 2; m++) begin
                logic        ack, err;
                logic [31:0] rdata;
                ack   = m ? m1_ack : m0_ack;
                err   = m ? m1_err : m0_err;
                rdata = m ? m1_rdata : m0_rdata;
                if (ack) begin
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL unexpected_ack @cyc %0d: got ack on m%0d want none", cyc, m);
                    end else begin
                        exp_t e;
                        e = exp_q.pop_front();
                        chk("ack_master", 32'(m), 32'(e.m));
                        chk("ack_cycle", 32'(cyc), 32'(e.ack_cyc));
                        chk("err", 32'(err), 32'(e.err));
                        if (e.rd) chk("rdata", rdata, e.rdata);
                    end
                end
            end
            while (exp_q.size() > 0 && exp_q[0].ack_cyc < cyc) begin
                n_cmp++;
                n_bad++;
                $display("FAIL missing_ack @cyc %0d: got no ack want m%0d at cyc %0d",
                         cyc, exp_q[0].m, exp_q[0].ack_cyc);
                void'(exp_q.pop_front());
            end
        end
    end

    function automatic logic [31:0] pick_addr();
        int r;
        r = int'($urandom_range(0, 19));
        if (r < 16) return addr_tab[r];
        if (r < 19) return $urandom & 32'h0000_7FFC;
        return $urandom;
    endfunction

    task automatic issue(input int m, input logic [31:0] a, input logic [31:0] w, input logic [3:0] be);
        if (m == 0) begin
            m0_req = 1'b1; m0_addr = a; m0_wdata = w; m0_byteen = be;
        end else begin
            m1_req = 1'b1; m1_addr = a; m1_wdata = w; m1_byteen = be;
        end
    endtask

    task automatic issue_rand(input int m);
        logic [3:0] be;
        be = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
        issue(m, pick_addr(), $urandom, be);
    endtask

    // One clock of master behaviour: drop req on ack (scrambling payload), else maybe raise.
    task automatic tick();
        @(negedge clk);
        if (m0_ack) begin
            m0_req = 1'b0; m0_addr = $urandom; m0_wdata = $urandom; m0_byteen = 4'($urandom);
        end else if (!m0_req && raise_pct > 0 && int'($urandom_range(0, 99)) < raise_pct) begin
            issue_rand(0);
        end
        if (m1_ack) begin
            m1_req = 1'b0; m1_addr = $urandom; m1_wdata = $urandom; m1_byteen = 4'($urandom);
        end else if (!m1_req && raise_pct > 0 && int'($urandom_range(0, 99)) < raise_pct) begin
            issue_rand(1);
        end
    endtask

    task automatic wait_quiet();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 300 && !done; i++) begin
            tick();
            done = !m0_req && !m1_req && !busy && (exp_q.size() == 0);
        end
        if (!done) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain_timeout @cyc %0d: got pending=%0d want 0", cyc, exp_q.size());
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        addr_tab = '{32'h0000_0000, 32'h0000_0010, 32'h0000_2FFC, 32'h0000_2FFF,
                     32'h0000_3000, 32'h0000_7F00, 32'h0000_7F04, 32'h0000_7F0B,
                     32'h0000_7F0C, 32'h0000_7F10, 32'h0000_7F1B, 32'h0000_7F1C,
                     32'h0000_7F20, 32'h0000_7F24, 32'h0000_5000, 32'h0001_0010};
        salt  = $urandom;
        reset = 1'b1;
        m0_req = 1'b0; m0_addr = '0; m0_wdata = '0; m0_byteen = '0;
        m1_req = 1'b0; m1_addr = '0; m1_wdata = '0; m1_byteen = '0;
        repeat (3) @(negedge clk);
        chk("rst_bus_addr", bus_addr, 32'h0);
        chk("rst_bus_wdata", bus_wdata, 32'h0);
        chk("rst_bus_byteen", 32'(bus_byteen), 32'h0);
        chk("rst_m0_ack", 32'(m0_ack), 32'h0);
        chk("rst_m1_ack", 32'(m1_ack), 32'h0);
        chk("rst_m0_rdata", m0_rdata, 32'h0);
        chk("rst_m1_rdata", m1_rdata, 32'h0);
        chk("rst_m0_err", 32'(m0_err), 32'h0);
        chk("rst_m1_err", 32'(m1_err), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        reset  = 1'b0;
        mon_en = 1'b1;

        // Directed: mapped read, mapped write from m1, unmapped write.
        tick(); issue(0, 32'h0000_0010, 32'h0, 4'h0);            wait_quiet();
        tick(); issue(1, 32'h0000_7F04, 32'h0000_00FF, 4'hF);    wait_quiet();
        tick(); issue(0, 32'h0000_5000, 32'h1234_5678, 4'hF);    wait_quiet();
        chk("unmapped_rdata", m0_rdata, 32'h0);

        // Simultaneous requests, then random traffic, then saturation.
        tick(); issue(0, 32'h0000_7F10, 32'h0, 4'h0); issue(1, 32'h0000_7F20, 32'h0, 4'h0);
        wait_quiet();
        raise_pct = 30;
        repeat (600) tick();
        raise_pct = 100;
        repeat (60) tick();
        raise_pct = 0;
        wait_quiet();

        // Reset during the ACCESS cycle of an m0 write aborts it.
        tick(); issue(0, 32'h0000_7F04, 32'hCAFE_0001, 4'hF);
        tick();
        reset  = 1'b1;
        m0_req = 1'b0;
        tick();
        chk("abort_bus_byteen", 32'(bus_byteen), 32'h0);
        chk("abort_m0_ack", 32'(m0_ack), 32'h0);
        chk("abort_busy", 32'(busy), 32'h0);
        chk("abort_m0_rdata", m0_rdata, 32'h0);
        tick();
        reset = 1'b0;
        tick(); issue(0, 32'h0000_0100, 32'h0, 4'h0); issue(1, 32'h0000_0200, 32'h0, 4'h0);
        wait_quiet();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mmio_arbiter.md
MMIO_ARBITER -- requirements
Module: mmio_arbiter

Interface
REQ-001 The block SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-003 The block SHALL have port m0_req, input, 1 bit: CPU data-port request; held high until the matching ack.
REQ-004 The block SHALL have ports m0_addr (input, 32 bits), m0_wdata (input, 32 bits) and m0_byteen (input, 4 bits): CPU request payload; byteen of 0 means read, nonzero means write.
REQ-005 The block SHALL have port m0_ack, output, 1 bit: one-cycle completion pulse to the CPU.
REQ-006 The block SHALL have ports m0_rdata (output, 32 bits) and m0_err (output, 1 bit): read data and unmapped-address flag, both valid while m0_ack is high.
REQ-007 The block SHALL have ports m1_req, m1_addr, m1_wdata, m1_byteen, m1_ack, m1_rdata and m1_err with the same widths and meanings as m0, for the DMA/debug master.
REQ-008 The block SHALL have ports bus_addr (output, 32 bits), bus_wdata (output, 32 bits) and bus_byteen (output, 4 bits): shared peripheral bus toward the DM/timer bridge.
REQ-009 The block SHALL have port bus_rdata, input, 32 bits: bridge read data.
REQ-010 The block SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.

Function
REQ-011 The FSM SHALL have three states: IDLE, ACCESS and DONE; IDLE goes to ACCESS when any req is high, ACCESS always goes to DONE, and DONE always goes to IDLE.
REQ-012 In IDLE, with at least one req high, the block SHALL select a grant and register the winner's addr, wdata and byteen into internal holding registers.
REQ-013 In ACCESS, the block SHALL drive bus_addr and bus_wdata from the holding registers and drive bus_byteen from the holding register for exactly that one cycle.
REQ-014 bus_byteen SHALL be 0 in every state other than ACCESS, so no write strobe occurs outside ACCESS.
REQ-015 The block SHALL sample bus_rdata at the end of ACCESS into the granted master's rdata register.
REQ-016 In DONE, the block SHALL pulse the granted master's ack; the other master's ack SHALL remain 0.
REQ-017 Request-to-ack latency SHALL be fixed at 2 cycles: req seen in IDLE at cycle N, ack at cycle N+2; throughput SHALL be 1 transaction per 3 cycles.
REQ-018 Requests SHALL NOT be sampled in DONE, so a req still high during its ack cycle is not serviced twice; a master may re-request from the cycle after its ack.
REQ-019 Address decode SHALL map the following ranges: DM 0x0000_0000-0x0000_2FFF, TC0 0x0000_7F00-0x0000_7F0B, TC1 0x0000_7F10-0x0000_7F1B, INT 0x0000_7F20.
REQ-020 For an unmapped address, the block SHALL still traverse ACCESS but force bus_byteen to 0, load rdata with 0, and assert err together with ack in DONE.
REQ-021 For a mapped address, err SHALL be 0.
REQ-022 rdata for a write transaction SHALL be don't-care; the bench SHALL NOT check it.
REQ-023 The holding registers SHALL be unaffected by requester input changes after the IDLE capture cycle.
REQ-024 A last_grant register SHALL record the master served most recently; it SHALL update when leaving IDLE.

Reset
REQ-025 While reset is high at a rising clk edge, the state SHALL become IDLE, and bus_addr, bus_wdata, bus_byteen, m0/m1_ack, m0/m1_rdata, m0/m1_err and busy SHALL become 0.
REQ-026 Reset SHALL set last_grant to 1, so m0 wins the first tie.
REQ-027 Reset asserted mid-transaction SHALL abort the transaction: no ack is produced, and bus_byteen is 0 in the cycle after the reset edge even if the state was ACCESS.

Configuration
REQ-028 With macro MMIO_ARB_ROUND_ROBIN_EN defined, on simultaneous requests the block SHALL grant the master that is not last_grant; a single requester SHALL always be granted.
REQ-029 Without MMIO_ARB_ROUND_ROBIN_EN, the block SHALL use fixed priority: m0 wins every tie; last_grant is still maintained but SHALL NOT affect arbitration.

Verification
REQ-030 Reset, then m0 read 0x0000_0010 with bus_rdata=0xDEAD_BEEF -> bus_byteen=0 throughout, m0_ack at cycle +2, m0_rdata=0xDEAD_BEEF, m0_err=0.
REQ-031 m1 write 0x0000_7F04, wdata=0x0000_00FF, byteen=0xF -> bus_byteen=0xF for exactly one cycle with bus_addr=0x0000_7F04, m1_ack at cycle +2, m0_ack=0.
REQ-032 With MMIO_ARB_ROUND_ROBIN_EN defined, m0 and m1 both held high for 4 transactions -> grants alternate m0,m1,m0,m1; without the macro -> m0,m0,m0,m0 with m1 never acked.
REQ-033 m0 write to 0x0000_5000 with byteen=0xF -> bus_byteen stays 0, m0_ack=1, m0_err=1, m0_rdata=0.
REQ-034 Reset asserted during ACCESS of an m0 write -> next cycle state IDLE, bus_byteen=0, no m0_ack; after reset, first tie goes to m0.
